fp_vec_sub_seq: RTL

- Job-level sequencer that sits directly upstream of fp_subber_driver.
- It accepts a stream of FP32 operand pairs (a, b) for a job of job_len elements and issues one request per pair over the driver's start/busy/done interface.
- It captures each z result into an output FIFO and presents results as a ready/valid stream, with out_last marking the final element of the job.
- It converts the driver's one-at-a-time level-done handshake into back-pressured streaming for the EPU datapath.

---
 rtl/fp_epu_pkg.sv | 26 ++
 rtl/fp_res_fifo.sv | 61 ++++++
 rtl/fp_vec_sub_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fp_epu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fp_epu_pkg
// Purpose  : Shared types for the FP32 vector-subtract job sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package fp_epu_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } seq_state_t;

  // Result FIFO entry: last flag rides above the 32-bit result.
  typedef struct packed {
    logic              last;
    logic [FP32_W-1:0] z;
  } res_t;

endpackage
`default_nettype wire

// File: rtl/fp_res_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fp_res_fifo
// Purpose  : First-word fall-through result FIFO, power-of-two depth.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fp_res_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != c_DEPTH_CNT);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fp_vec_sub_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fp_vec_sub_seq
// Purpose  : Job sequencer feeding fp_subber_driver one pair at a time and
//            streaming its results out through a back-pressured FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fp_vec_sub_seq
  import fp_epu_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  input  logic [LEN_W-1:0]  job_len,
  output logic              job_busy,
  output logic              job_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_a,
  input  logic [FP32_W-1:0] in_b,
  output logic              drv_start,
  output logic [FP32_W-1:0] drv_a,
  output logic [FP32_W-1:0] drv_b,
  input  logic              drv_busy,
  input  logic              drv_done,
  input  logic [FP32_W-1:0] drv_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_z,
  output logic              out_last
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [CW-1:0]    c_DEPTH_CNT = CW'(OUT_DEPTH);
  localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  w_remaining_nxt;
  logic [FP32_W-1:0] r_drv_a;
  logic [FP32_W-1:0] r_drv_b;
  logic              r_job_done;
  logic              w_job_done_nxt;
  logic              w_in_ready;
  logic              w_drv_start;
  logic              w_load_ops;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [CW-1:0]     w_fifo_count;
  res_t              w_push_data;
  res_t              w_head;

  assign w_push_data = '{last: (r_remaining == c_ONE), z: drv_z};

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_job_done_nxt  = 1'b0;
    w_in_ready      = 1'b0;
    w_drv_start     = 1'b0;
    w_load_ops      = 1'b0;
    w_push          = 1'b0;
    case (r_state)
      IDLE: begin
        if (job_start) begin
          w_remaining_nxt = job_len;
          if (job_len == '0) w_job_done_nxt = 1'b1;
          else               w_state_nxt    = FETCH;
        end
      end
      FETCH: begin
        // Only take a pair when its result is guaranteed a FIFO slot.
        w_in_ready = (w_fifo_count < c_DEPTH_CNT);
        if (in_valid && w_in_ready) begin
          w_load_ops  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_drv_start = 1'b1;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // drv_done may still be high from the previous element; wait for busy.
        if (drv_busy) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!drv_busy && drv_done) begin
          w_push          = 1'b1;
          w_remaining_nxt = r_remaining - c_ONE;
          if (r_remaining == c_ONE) begin
            w_job_done_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt = FETCH;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_drv_a     <= '0;
      r_drv_b     <= '0;
      r_job_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_job_done  <= w_job_done_nxt;
      if (w_load_ops) begin
        r_drv_a <= in_a;
        r_drv_b <= in_b;
      end
    end
  end

  assign w_pop = w_fifo_valid && out_ready;

  fp_res_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_fifo_count)
  );

  assign job_busy  = (r_state != IDLE);
  assign job_done  = r_job_done;
  assign in_ready  = w_in_ready;
  assign drv_start = w_drv_start;
  assign drv_a     = r_drv_a;
  assign drv_b     = r_drv_b;
  assign out_valid = w_fifo_valid;
  assign out_z     = w_head.z;
  assign out_last  = w_head.last;

endmodule
`default_nettype wire
